alu_bus_arbiter: RTL and testbench
==================================

ALU_BUS_ARBITER -- requirements
Module: alu_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum GRANT-state cycles per transaction before forced revoke; legal range 2..255.
REQ-002 The block SHALL have exactly one clock and one reset: clock is clk, rising-edge; reset is rst, synchronous, active-high.
REQ-003 clk  input  1  clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  16  per-requester bus request; bit i asserts a request for mux input i.
REQ-006 done  input  1  consumer accepted the current mux output this cycle.
REQ-007 sel  output  4  binary index of the granted requester; drives the 16:1 16-bit mux select.
REQ-008 grant  output  16  one-hot grant, grant[sel] when valid.
REQ-009 valid  output  1  mux output currently owned by a granted requester.
REQ-010 timeout  output  1  single-cycle pulse on a forced revoke.
REQ-011 xfer_cnt  output  8  count of completed transfers (done accepted), saturating.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE and GRANT; all outputs registered.
REQ-013 IDLE: valid=0, grant=0, sel holds its last value; if req!=0, select the first set req bit at or above ptr, searching upward and wrapping 15->0, and enter GRANT next cycle.
REQ-014 Arbitration latency SHALL be exactly 1 cycle: req seen in IDLE at edge N -> valid=1, grant, sel valid after edge N+1.
REQ-015 GRANT: valid=1, grant=1<<sel, hold counter increments every cycle, starting at 0 on entry.
REQ-016 GRANT + done=1: xfer_cnt increments (saturates at 255), ptr=sel+1 mod 16, next state IDLE.
REQ-017 GRANT + done=0 + req[sel]=0 (abort): ptr=sel+1 mod 16, next state IDLE, xfer_cnt unchanged, no timeout.
REQ-018 GRANT + done=0 + req[sel]=1 + hold counter = MAX_HOLD-1: timeout=1 for the next cycle only, ptr=sel+1 mod 16, next state IDLE.
REQ-019 Priority in GRANT SHALL be done > abort > timeout when asserted in the same cycle.
REQ-020 Every GRANT exit SHALL pass through at least one IDLE cycle (valid=0) before the next grant.
REQ-021 The granted index SHALL not change while in GRANT, regardless of req changes on other bits.
REQ-022 done while in IDLE SHALL be ignored (no count, no state change).
REQ-023 grant SHALL be one-hot or zero at all times; valid=1 iff grant!=0.

Reset
REQ-024 rst=1 at a rising edge SHALL force: state IDLE, ptr=0, sel=0, grant=0, valid=0, timeout=0, xfer_cnt=0, hold counter=0.
REQ-025 rst SHALL override all other inputs, including mid-GRANT; the first grant after rst deasserts SHALL follow REQ-013 with ptr=0.

Verification
REQ-026 After reset, req=16'h0001, done=1 on second GRANT cycle -> valid rises 1 cycle after req, sel=0, grant=16'h0001, xfer_cnt=1, valid=0 next cycle.
REQ-027 Round-robin: req=16'hFFFF held, done=1 every GRANT cycle -> sel sequence 0,1,2,...,15,0 with one IDLE bubble between grants.
REQ-028 Wrap: ptr=15 (after serving 14), req=16'h0011 -> grant sel=0, then sel=4.
REQ-029 Timeout: MAX_HOLD=8, req=16'h0020 held, done=0 -> valid high 8 cycles, timeout pulse 1 cycle, IDLE, then re-grant sel=5 (only requester).
REQ-030 Abort/priority: in GRANT sel=3, drop req[3] with done=1 same cycle -> counted as transfer, xfer_cnt+1, timeout=0; drop req[3] with done=0 -> IDLE, xfer_cnt unchanged.
REQ-031 Reset mid-GRANT: sel=9 granted, assert rst one cycle -> all outputs zero next cycle; 256 completed transfers -> xfer_cnt=255.

Source files
------------

// File: rtl/alu_bus_arbiter_if.sv
// Request/grant bundle between the requesters, the 16:1 mux consumer and the arbiter.
// master drives requests and done; slave is the arbiter side.
interface alu_bus_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        timeout;
  logic [7:0]  xfer_cnt;

  modport master (
    output req, done,
    input  sel, grant, valid, timeout, xfer_cnt
  );

  modport slave (
    input  req, done,
    output sel, grant, valid, timeout, xfer_cnt
  );
endinterface

// File: rtl/alu_bus_arbiter.sv
// Round-robin arbiter for a 16:1 bus mux with a bounded hold time per grant.
// All outputs are registered; the search pointer advances past the last owner on every release.
module alu_bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  alu_bus_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic [3:0]  sel_reg, sel_next;
  logic [15:0] grant_reg, grant_next;
  logic        valid_reg, valid_next;
  logic        timeout_reg, timeout_next;
  logic [7:0]  xfer_cnt_reg, xfer_cnt_next;
  logic [7:0]  hold_reg, hold_next;

  logic [31:0] req_dbl;
  logic [15:0] req_rot;
  logic [3:0]  pick_offset;
  logic [3:0]  pick;
  logic [15:0] pick_onehot;
  logic [3:0]  sel_inc;

  // Rotating the request vector so bit 0 corresponds to ptr turns the wrapped search into a plain priority encode.
  assign req_dbl = {bus.req, bus.req};

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
      logic [4:0] idx;
      assign idx         = 5'(gi) + {1'b0, ptr_reg};
      assign req_rot[gi] = req_dbl[idx];
    end
  endgenerate

  always_comb begin
    pick_offset = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) pick_offset = 4'(i);
    end
  end

  assign pick    = ptr_reg + pick_offset;
  assign sel_inc = sel_reg + 4'd1;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 4'd0;
      sel_reg      <= 4'd0;
      grant_reg    <= 16'h0000;
      valid_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      xfer_cnt_reg <= 8'd0;
      hold_reg     <= 8'd0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      sel_reg      <= sel_next;
      grant_reg    <= grant_next;
      valid_reg    <= valid_next;
      timeout_reg  <= timeout_next;
      xfer_cnt_reg <= xfer_cnt_next;
      hold_reg     <= hold_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    sel_next      = sel_reg;
    grant_next    = grant_reg;
    valid_next    = valid_reg;
    timeout_next  = 1'b0;
    xfer_cnt_next = xfer_cnt_reg;
    hold_next     = hold_reg;

    case (state_reg)
      IDLE: begin
        grant_next = 16'h0000;
        valid_next = 1'b0;
        hold_next  = 8'd0;
        if (bus.req != 16'h0000) begin
          state_next = GRANT;
          sel_next   = pick;
          grant_next = pick_onehot;
          valid_next = 1'b1;
        end
      end
      GRANT: begin
        hold_next = hold_reg + 8'd1;
        // Exit order encodes the priority: a completed transfer beats an abort, which beats a forced revoke.
        if (bus.done || !bus.req[sel_reg] || (hold_reg == 8'(MAX_HOLD - 1))) begin
          state_next = IDLE;
          ptr_next   = sel_inc;
          grant_next = 16'h0000;
          valid_next = 1'b0;
          hold_next  = 8'd0;
          if (bus.done) begin
            if (xfer_cnt_reg != 8'hFF) xfer_cnt_next = xfer_cnt_reg + 8'd1;
          end else if (bus.req[sel_reg]) begin
            timeout_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 16'h0000;
        valid_next = 1'b0;
      end
    endcase
  end

  assign bus.sel      = sel_reg;
  assign bus.grant    = grant_reg;
  assign bus.valid    = valid_reg;
  assign bus.timeout  = timeout_reg;
  assign bus.xfer_cnt = xfer_cnt_reg;

endmodule

// File: tb/tb_alu_bus_arbiter.sv
// Randomised and directed bench for alu_bus_arbiter against an owner/pointer reference model.
module tb_alu_bus_arbiter;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst;
  alu_bus_arbiter_if bus ();

  alu_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus (-1 = nobody), where the next search starts, and counters.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_held  = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  function automatic void model_step(input logic [15:0] r, input logic d, input logic rs);
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_cnt = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 16; k++) begin
        if (r[(m_ptr + k) % 16]) begin
          m_owner = (m_ptr + k) % 16;
          m_sel   = m_owner;
          m_held  = 0;
          break;
        end
      end
    end else if (d) begin
      if (m_cnt < 255) m_cnt++;
      m_ptr = (m_owner + 1) % 16; m_owner = -1;
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 16; m_owner = -1;
    end else if (m_held == MAX_HOLD - 1) begin
      m_to = 1'b1;
      m_ptr = (m_owner + 1) % 16; m_owner = -1;
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [29:0] model_out();
    logic [15:0] g;
    g = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0000;
    return {(m_owner >= 0), g, 4'(m_sel), m_to, 8'(m_cnt)};
  endfunction

  function automatic logic [29:0] dut_out();
    return {bus.valid, bus.grant, bus.sel, bus.timeout, bus.xfer_cnt};
  endfunction

  task automatic cyc(input logic [15:0] r, input logic d, input logic rs);
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    model_step(r, d, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(16'($urandom()), 1'($urandom()), 1'b1);
      n_cmp++;
      if (dut_out() !== 30'h0) begin
        n_bad++;
        $display("FAIL reset_state: got %h want %h", dut_out(), 30'h0);
      end
    end
    cyc(16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (dut_out() !== model_out()) begin
      n_bad++;
      $display("FAIL idle_done_ignored: got %h want %h", dut_out(), model_out());
    end
  endtask

  task automatic test_basic();
    logic [15:0] rs [4] = '{16'h0, 16'h1, 16'h1, 16'h1};
    logic        ds [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        rr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(rs[i], ds[i], rr[i]);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL basic_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
      if (i == 1) begin
        n_cmp++;
        if ({bus.valid, bus.sel, bus.grant} !== {1'b1, 4'd0, 16'h0001}) begin
          n_bad++;
          $display("FAIL basic_latency: got v=%b sel=%0d grant=%h want v=1 sel=0 grant=0001",
                   bus.valid, bus.sel, bus.grant);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if ({bus.valid, bus.xfer_cnt} !== {1'b0, 8'd1}) begin
          n_bad++;
          $display("FAIL basic_done: got v=%b cnt=%0d want v=0 cnt=1", bus.valid, bus.xfer_cnt);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int seq [$];
    logic prev_valid;
    cyc(16'h0, 1'b0, 1'b1);
    prev_valid = 1'b0;
    for (int i = 0; i < 34; i++) begin
      cyc(16'hFFFF, 1'b1, 1'b0);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL rr_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
      if (bus.valid) seq.push_back(int'(bus.sel));
      n_cmp++;
      if (prev_valid && bus.valid) begin
        n_bad++;
        $display("FAIL rr_bubble%0d: got back-to-back valid want idle gap", i);
      end
      prev_valid = bus.valid;
    end
    for (int k = 0; k < 17; k++) begin
      n_cmp++;
      if (k >= seq.size() || seq[k] != (k % 16)) begin
        n_bad++;
        $display("FAIL rr_seq%0d: got %0d want %0d", k, (k < seq.size()) ? seq[k] : -1, k % 16);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] rs [6] = '{16'h0, 16'h4000, 16'h4000, 16'h0011, 16'h0011, 16'h0011};
    logic        ds [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cyc(rs[i], ds[i], i == 0);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL wrap_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
    n_cmp++;
    if ({bus.valid, bus.sel} !== {1'b1, 4'd4}) begin
      n_bad++;
      $display("FAIL wrap_second: got v=%b sel=%0d want v=1 sel=4", bus.valid, bus.sel);
    end
  endtask

  task automatic test_timeout();
    logic       v [1:12];
    logic       t [1:12];
    logic [3:0] s [1:12];
    int run;
    cyc(16'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      cyc(16'h0020, 1'b0, 1'b0);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL timeout_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
      v[i] = bus.valid; t[i] = bus.timeout; s[i] = bus.sel;
    end
    run = 0;
    for (int i = 1; i <= 12 && v[i]; i++) run++;
    n_cmp++;
    if (run != MAX_HOLD) begin
      n_bad++;
      $display("FAIL timeout_hold: got %0d valid cycles want %0d", run, MAX_HOLD);
    end
    n_cmp++;
    if ({v[9], t[9], v[10], t[10], s[10]} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'd5}) begin
      n_bad++;
      $display("FAIL timeout_pulse: got v9=%b t9=%b v10=%b t10=%b sel10=%0d want 0 1 1 0 5",
               v[9], t[9], v[10], t[10], s[10]);
    end
  endtask

  task automatic test_abort_priority();
    logic [15:0] rs [5] = '{16'h0, 16'h0008, 16'h0000, 16'h0008, 16'h0000};
    logic        ds [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [9:0]  want [5] = '{10'h0, {1'b1, 4'd3, 1'b0, 4'd0}, {1'b0, 4'd3, 1'b0, 4'd1},
                              {1'b1, 4'd3, 1'b0, 4'd1}, {1'b0, 4'd3, 1'b0, 4'd1}};
    for (int i = 0; i < 5; i++) begin
      cyc(rs[i], ds[i], i == 0);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL abort_cycle%0d: got %h want %h", i, dut_out(), model_out());
      end
      n_cmp++;
      if ({bus.valid, bus.sel, bus.timeout, bus.xfer_cnt[3:0]} !== want[i]) begin
        n_bad++;
        $display("FAIL abort_step%0d: got %h want %h", i,
                 {bus.valid, bus.sel, bus.timeout, bus.xfer_cnt[3:0]}, want[i]);
      end
    end
  endtask

  task automatic test_reset_saturate();
    logic [15:0] r;
    cyc(16'h0, 1'b0, 1'b1);
    cyc(16'h0200, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.valid, bus.sel} !== {1'b1, 4'd9}) begin
      n_bad++;
      $display("FAIL mid_grant_setup: got v=%b sel=%0d want v=1 sel=9", bus.valid, bus.sel);
    end
    cyc(16'h0200, 1'b1, 1'b1);
    n_cmp++;
    if (dut_out() !== 30'h0) begin
      n_bad++;
      $display("FAIL mid_grant_reset: got %h want %h", dut_out(), 30'h0);
    end
    for (int i = 0; i < 258; i++) begin
      r = 16'($urandom()) | 16'h0001;
      cyc(r, 1'b0, 1'b0);
      cyc(r, 1'b1, 1'b0);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL saturate_xfer%0d: got %h want %h", i, dut_out(), model_out());
      end
    end
    n_cmp++;
    if (bus.xfer_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL saturate_final: got %0d want 255", bus.xfer_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic        d, rs;
    r = 16'($urandom());
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r = 16'($urandom()) & 16'($urandom());
      d  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 99) == 0);
      cyc(r, d, rs);
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_bad++;
        $display("FAIL random_cycle%0d: req=%h done=%b rst=%b got %h want %h",
                 i, r, d, rs, dut_out(), model_out());
      end
      n_cmp++;
      if (!$onehot0(bus.grant) || (bus.valid !== (bus.grant != 16'h0))) begin
        n_bad++;
        $display("FAIL random_onehot%0d: got grant=%h valid=%b want one-hot/valid match",
                 i, bus.grant, bus.valid);
      end
    end
  endtask

  initial begin
    bus.req  = 16'h0;
    bus.done = 1'b0;
    rst      = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_abort_priority();
    test_reset_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
